// File: rtl/b8_rr_arbiter_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: state encodings and
// default hold limit.
package b8_rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_MAX_HOLD = 16;
  localparam int unsigned N_REQ            = 8;

endpackage

// File: rtl/b8_rr_picker.sv
// Combinational round-robin search: first set candidate bit starting at the
// pointer and wrapping modulo 8.
module b8_rr_picker
  import b8_rr_arbiter_pkg::*;
(
  input  logic [7:0] i_cand,
  input  logic [2:0] i_ptr,
  output logic       o_found,
  output logic [2:0] o_idx
);

  logic [2:0] w_try;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_try   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_try = i_ptr + 3'(k);
      if (!o_found && i_cand[w_try]) begin
        o_found = 1'b1;
        o_idx   = w_try;
      end
    end
  end

endmodule

// File: rtl/b8_rr_arbiter.sv
// Round-robin arbiter for eight requesters sharing one 8-to-1 multiplexer,
// with hold-time preemption of an owner that keeps the resource too long.
module b8_rr_arbiter
  import b8_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] r7_r0,
  output logic [7:0] g7_g0,
  output logic [2:0] b2_b0,
  output logic       gv
);

  localparam logic [CNT_W-1:0] HOLD_LIM =
    (MAX_HOLD == 0) ? '1 : CNT_W'(MAX_HOLD);
  localparam logic             PREEMPT_EN = (MAX_HOLD != 0);

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_last, w_last_nxt;
  logic [2:0]       r_sel, w_sel_nxt;
  logic [7:0]       r_grant, w_grant_nxt;
  logic             r_gv, w_gv_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic [7:0] w_owner_bit;
  logic       w_owner_req;
  logic [7:0] w_cand;
  logic [2:0] w_ptr;
  logic       w_found;
  logic [2:0] w_idx;
  logic       w_take;

  // Owner bit is masked whenever BUSY, so release and preemption share one search.
  assign w_owner_bit = 8'b1 << r_sel;
  assign w_owner_req = |(r7_r0 & w_owner_bit);
  assign w_cand      = (r_state == BUSY) ? (r7_r0 & ~w_owner_bit) : r7_r0;
  assign w_ptr       = r_last + 3'd1;

  b8_rr_picker u_picker (
    .i_cand  (w_cand),
    .i_ptr   (w_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_take = 1'b0;
    unique case (r_state)
      IDLE:    w_take = w_found;
      BUSY:    w_take = w_found &&
                        (!w_owner_req || (PREEMPT_EN && (r_cnt == HOLD_LIM)));
      default: w_take = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_sel_nxt   = r_sel;
    w_grant_nxt = r_grant;
    w_gv_nxt    = r_gv;
    w_cnt_nxt   = r_cnt;
    if (w_take) begin
      w_state_nxt = BUSY;
      w_last_nxt  = w_idx;
      w_sel_nxt   = w_idx;
      w_grant_nxt = 8'b1 << w_idx;
      w_gv_nxt    = 1'b1;
      w_cnt_nxt   = CNT_W'(1);
    end else if (r_state == BUSY && !w_owner_req) begin
      w_state_nxt = IDLE;
      w_grant_nxt = '0;
      w_gv_nxt    = 1'b0;
      w_cnt_nxt   = '0;
    end else if (r_state == BUSY && r_cnt != HOLD_LIM) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 3'd7;
      r_sel   <= '0;
      r_grant <= '0;
      r_gv    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_sel   <= w_sel_nxt;
      r_grant <= w_grant_nxt;
      r_gv    <= w_gv_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign g7_g0 = r_grant;
  assign b2_b0 = r_sel;
  assign gv    = r_gv;

endmodule

// File: tb/tb_b8_rr_arbiter.sv
// Self-checking bench for b8_rr_arbiter: directed scenarios plus random
// traffic against a behavioural round-robin model.
module tb_b8_rr_arbiter;

  localparam int MH    = 4;
  localparam int BOUND = 7 * MH + 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] r7_r0;
  logic [7:0] g7_g0;
  logic [2:0] b2_b0;
  logic       gv;

  int n_checks = 0;
  int n_err    = 0;

  // behavioural model
  int         m_owner;
  int         m_last;
  int         m_held;
  logic [2:0] m_sel;
  int         waits[8];
  int         max_wait;

  b8_rr_arbiter #(.MAX_HOLD(MH), .CNT_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .r7_r0 (r7_r0),
    .g7_g0 (g7_g0),
    .b2_b0 (b2_b0),
    .gv    (gv)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] c, input int ptr);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (ptr + k) % 8;
      if (c[i]) return i;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_owner = -1;
    m_last  = 7;
    m_held  = 0;
    m_sel   = 3'd0;
    for (int i = 0; i < 8; i++) waits[i] = 0;
  endtask

  task automatic m_grant(input int p);
    m_owner = p;
    m_last  = p;
    m_held  = 1;
    m_sel   = 3'(p);
  endtask

  task automatic m_edge(input logic [7:0] req);
    logic [7:0] others;
    int p;
    if (m_owner < 0) begin
      p = pick(req, (m_last + 1) % 8);
      if (p >= 0) m_grant(p);
    end else begin
      others = req;
      others[m_owner] = 1'b0;
      p = pick(others, (m_last + 1) % 8);
      if (!req[m_owner]) begin
        if (p >= 0) m_grant(p);
        else begin
          m_owner = -1;
          m_held  = 0;
        end
      end else if (m_held >= MH && p >= 0) begin
        m_grant(p);
      end else begin
        m_held++;
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (req[i] && m_owner != i) waits[i]++;
      else waits[i] = 0;
      if (waits[i] > max_wait) max_wait = waits[i];
    end
  endtask

  function automatic logic [7:0] m_gnt();
    logic [7:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic step(input string tag, input logic [7:0] req);
    r7_r0 = req;
    @(posedge clock);
    m_edge(req);
    #1;
    check({tag, ".grant"}, g7_g0, m_gnt());
    check({tag, ".gv"},    {7'd0, gv}, {7'd0, m_owner >= 0});
    check({tag, ".sel"},   {5'd0, b2_b0}, {5'd0, m_sel});
  endtask

  initial begin
    logic [7:0] req;
    max_wait = 0;
    reset = 1'b1;
    r7_r0 = '0;
    m_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset.grant", g7_g0, 8'h00);
    check("reset.gv",    {7'd0, gv}, 8'h00);
    check("reset.sel",   {5'd0, b2_b0}, 8'h00);
    @(negedge clock);
    reset = 1'b0;

    // first grant, then back-to-back handover on release
    step("first", 8'b0000_0101);
    check("first.const", g7_g0, 8'b0000_0001);
    step("handover", 8'b0000_0100);
    check("handover.const", g7_g0, 8'b0000_0100);
    step("idle", 8'h00);

    // wrap-around from owner 7
    step("own7", 8'b1000_0000);
    step("own7b", 8'b1000_0001);
    step("wrap", 8'b0000_0001);
    check("wrap.const", g7_g0, 8'b0000_0001);
    step("idle2", 8'h00);

    // preemption between two persistent requesters
    for (int c = 0; c < 12; c++) begin
      step("preempt", 8'b0010_1000);
      check("preempt.const", g7_g0, (c / 4) % 2 == 0 ? 8'b0000_1000 : 8'b0010_0000);
    end
    step("idle3", 8'h00);

    // lone requester: counter saturates, no preemption
    for (int c = 0; c < 20; c++) begin
      step("lone", 8'b0000_0100);
      check("lone.const", g7_g0, 8'b0000_0100);
    end

    // asynchronous reset mid-grant
    step("pre_rst", 8'b0001_0000);
    #2 reset = 1'b1;
    #1;
    check("async_rst.grant", g7_g0, 8'h00);
    check("async_rst.gv",    {7'd0, gv}, 8'h00);
    check("async_rst.sel",   {5'd0, b2_b0}, 8'h00);
    m_reset();
    @(negedge clock);
    reset = 1'b0;
    step("after_rst", 8'hFF);
    check("after_rst.const", g7_g0, 8'b0000_0001);
    step("idle4", 8'h00);

    // random traffic: requesters hold until served, release randomly
    req = '0;
    max_wait = 0;
    for (int i = 0; i < 8; i++) waits[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 8; i++) begin
        if (req[i]) begin
          if (m_owner == i && $urandom_range(3) == 0) req[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          req[i] = 1'b1;
        end
      end
      step("rand", req);
      check("rand.onehot0", {7'd0, $onehot0(g7_g0)}, 8'h01);
      check("rand.gv_or",   {7'd0, gv}, {7'd0, |g7_g0});
    end
    n_checks++;
    assert (max_wait <= BOUND) else begin
      n_err++;
      $error("FAIL max_wait: observed %0d expected <= %0d", max_wait, BOUND);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/b8_rr_arbiter.md
# b8_rr_arbiter

Round-robin arbiter sharing one 8-to-1 multiplexer between eight requesters. Each requester raises its request line and holds it for as long as it needs the shared output. The arbiter grants exactly one requester at a time and drives the multiplexer's 3-bit select with the index of the granted requester. A hold-time limit preempts an owner that keeps the resource while others wait.

## Interface
- MAX_HOLD, 16: maximum consecutive grant cycles before preemption when other requests are pending; 0 disables preemption.
- CNT_W, 5: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- r7_r0  in  8  request lines, bit i = requester i; level-sensitive.
- g7_g0  out  8  one-hot grant, registered; all zero when idle.
- b2_b0  out  3  multiplexer select = index of granted requester; registered.
- gv  out  1  grant valid, registered; high iff g7_g0 is nonzero.

## Operation
- Two states: IDLE (no owner) and BUSY (owner = index in b2_b0).
- Pointer p = (last owner + 1) mod 8; pick = first i in p, p+1, …, p+7 (mod 8) with the candidate request bit set.
- IDLE: if r7_r0 != 0, pick among all requests -> BUSY, owner = pick, hold counter = 1; else stay IDLE.
- BUSY, owner's request low: release; candidates = r7_r0 with the owner bit masked. If any remain -> new owner = pick, counter = 1 (back-to-back, no dead cycle); else -> IDLE.
- BUSY, owner's request high, MAX_HOLD != 0, counter == MAX_HOLD, another bit set: preempt. Candidates = r7_r0 with the owner bit masked, new owner = pick, counter = 1.
- BUSY, otherwise: keep owner; counter increments, saturating at MAX_HOLD.
- Last owner updates on every new grant. The preempted owner's request stays pending and competes normally.
- IDLE outputs: g7_g0 = 0, gv = 0, b2_b0 holds its last value; the multiplexer output is don't-care.
- Requests of non-owners never affect the current grant except through preemption.

## Timing
- All outputs change only on the rising clock edge. Latency from request sampled high in IDLE to grant visible is 1 cycle.
- Release: owner's request sampled low at edge k; new grant or idle is visible after edge k. The owner is therefore granted for exactly as many cycles as its request was sampled high, counting from the grant cycle.
- Preemption: the owner has gv high for exactly MAX_HOLD cycles, then the next owner's grant is visible in the following cycle.
- Reset, asynchronous at any time including mid-grant: state IDLE, g7_g0 = 0, b2_b0 = 000, gv = 0, counter = 0, last owner = 7 so requester 0 has first priority.
- Reset deassertion: first arbitration at the first rising edge with reset low.
- Simultaneous release and preemption condition: treated as release; the owner bit is masked either way.
- Wrap-around: owner 7 -> search begins at 0.

## Structure
- Shared include file holds the state encodings (IDLE = 0, BUSY = 1) and the default MAX_HOLD.
- One combinational sub-module, b8_rr_picker. Inputs: 8-bit candidate vector and 3-bit pointer. Outputs: found flag and 3-bit index.
- One instance serves all three arbitration cases. The caller applies the owner mask before the picker.
- b2_b0 connects directly to the select of the existing 8-to-1 multiplexer.

## Test plan
- Reset, then r7_r0 = 00000101 at edge 1 -> after edge 1: g7_g0 = 00000001, b2_b0 = 000, gv = 1. Drop r0 -> next cycle g7_g0 = 00000100, b2_b0 = 010, no idle cycle.
- Owner 7 releases with r7_r0 = 10000001 (r7 still set before the drop) -> after release, g7_g0 = 00000001. Wrap-around is correct.
- MAX_HOLD = 4, r3 and r5 held continuously from idle -> r3 granted 4 cycles, r5 4 cycles, r3 again. No cycle has gv = 0.
- MAX_HOLD = 4, only r2 held for 20 cycles -> grant stays 00000100 throughout; the counter saturates and no preemption occurs.
- Assert reset mid-grant between edges -> g7_g0 = 0, gv = 0, b2_b0 = 000 immediately, without waiting for an edge. With all requests set after reset, requester 0 wins first.
- Random request traffic, 10k cycles -> g7_g0 is always one-hot or zero, and gv equals |g7_g0. b2_b0 equals the one-hot index whenever gv is high. No requester waits more than 7·MAX_HOLD + 8 cycles.
